// File: rtl/mod5_rr_scheduler.sv
// Two-requester round-robin front end for a serial mod-5 residue engine.
// Define MOD5_MSB_FIRST_EN to feed bits MSB-first (Horner form) instead of LSB-first weighted.
//   state   | meaning
//   S_IDLE  | waiting for a request; arbitration happens here
//   S_SHIFT | serialising the latched word into the residue accumulator
module mod5_rr_scheduler #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             busy,
   output logic             ser_bit,
   output logic             done,
   output logic [2:0]       result,
   output logic             result_id
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       acc_q, acc_d;
   logic             id_q, id_d;
   logic             last_id_q, last_id_d;
   logic             gnt_a_q, gnt_a_d;
   logic             gnt_b_q, gnt_b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2:0]       result_q, result_d;
   logic             result_id_q, result_id_d;
   logic             bit_in;
   logic             pick_b;
   logic [3:0]       acc_sum;
   logic [3:0]       acc_red;
`ifndef MOD5_MSB_FIRST_EN
   logic [2:0]       wgt_q, wgt_d;
   logic [3:0]       wgt_dbl;
   logic [3:0]       wgt_red;
`endif

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      id_d        = id_q;
      last_id_d   = last_id_q;
      gnt_a_d     = 1'b0;
      gnt_b_d     = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      result_d    = result_q;
      result_id_d = result_id_q;
      // Tie goes to whoever was not served last.
      pick_b      = req_b & (~req_a | ~last_id_q);
`ifdef MOD5_MSB_FIRST_EN
      bit_in  = shreg_q[WIDTH-1];
      acc_sum = {acc_q, 1'b0} + {3'b000, bit_in};
`else
      wgt_d   = wgt_q;
      bit_in  = shreg_q[0];
      acc_sum = {1'b0, acc_q} + (bit_in ? {1'b0, wgt_q} : 4'd0);
      wgt_dbl = {wgt_q, 1'b0};
      wgt_red = (wgt_dbl >= 4'd5) ? wgt_dbl - 4'd5 : wgt_dbl;
`endif
      acc_red = (acc_sum >= 4'd5) ? acc_sum - 4'd5 : acc_sum;

      case (state_q)
         S_IDLE: begin
            if (req_a || req_b) begin
               shreg_d   = pick_b ? data_b : data_a;
               cnt_d     = '0;
               acc_d     = 3'd0;
               id_d      = pick_b;
               last_id_d = pick_b;
               gnt_a_d   = ~pick_b;
               gnt_b_d   = pick_b;
               busy_d    = 1'b1;
               state_d   = S_SHIFT;
`ifndef MOD5_MSB_FIRST_EN
               wgt_d     = 3'd1;
`endif
            end
         end
         S_SHIFT: begin
            acc_d = acc_red[2:0];
            cnt_d = cnt_q + 1'b1;
`ifdef MOD5_MSB_FIRST_EN
            shreg_d = shreg_q << 1;
`else
            shreg_d = shreg_q >> 1;
            wgt_d   = wgt_red[2:0];
`endif
            if (cnt_q == CNT_LAST) begin
               result_d    = acc_red[2:0];
               result_id_d = id_q;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= 3'd0;
         id_q        <= 1'b0;
         last_id_q   <= 1'b1;
         gnt_a_q     <= 1'b0;
         gnt_b_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 3'd0;
         result_id_q <= 1'b0;
`ifndef MOD5_MSB_FIRST_EN
         wgt_q       <= 3'd1;
`endif
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         id_q        <= id_d;
         last_id_q   <= last_id_d;
         gnt_a_q     <= gnt_a_d;
         gnt_b_q     <= gnt_b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_id_q <= result_id_d;
`ifndef MOD5_MSB_FIRST_EN
         wgt_q       <= wgt_d;
`endif
      end
   end

   assign gnt_a     = gnt_a_q;
   assign gnt_b     = gnt_b_q;
   assign busy      = busy_q;
   assign ser_bit   = busy_q & bit_in;
   assign done      = done_q;
   assign result    = result_q;
   assign result_id = result_id_q;

endmodule
